pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline register for the core datapath, replacing bare write-enable registers between stages.
- Holds WIDTH bits with a valid/ready handshake on both sides, plus a synchronous flush for branch and exception squash.
- Optional 2-entry skid buffer fully registers the ready path, so no combinational path runs from i_ready to o_ready.
- Optional masking forces o_data to zero whenever o_valid is low.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- SKID, 1, 1 = 2-entry skid buffer with registered ready; 0 = single entry with combinational ready.
- RESET_VALUE, 0, WIDTH-bit value loaded into all data registers on reset.
- ZERO_INVALID, 0, 1 = o_data is driven to all-zeros while o_valid=0; 0 = o_data shows the main register unmasked.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_flush  in  1  synchronous squash of all held entries.
- i_data  in  WIDTH  upstream payload.
- i_valid  in  1  upstream payload valid.
- o_ready  out  1  stage can accept i_data this cycle.
- o_data  out  WIDTH  downstream payload.
- o_valid  out  1  o_data is valid.
- i_ready  in  1  downstream accepts this cycle.
- o_count  out  2  number of held entries: 0, 1 or 2.

Behaviour:
- Definitions: acc = i_valid & o_ready (upstream accept); ret = o_valid & i_ready (downstream retire). All updates take effect on the rising edge of clk.
- Reset, when reset=1 at an edge:
  - state goes to EMPTY; main and skid registers load RESET_VALUE.
  - o_ready=0 while reset is high.
  - Outputs after reset: o_valid=0, o_count=0, o_data = RESET_VALUE (or 0 if ZERO_INVALID=1).
  - Reset mid-transfer discards all entries, with no retire.
- Priority order: reset > i_flush > normal handshake.
- Flush, i_flush=1 (reset=0):
  - Next state is EMPTY; any acc in the same cycle is dropped.
  - ret in the flush cycle still counts as a downstream transfer.
  - Data registers hold their values; o_ready=1 on the next cycle.
- States when SKID=1. o_ready = (state != TWO), decoded only from the state register.
  - EMPTY (o_valid=0, o_count=0):
    - acc -> ONE, main <= i_data.
  - ONE (o_valid=1, o_count=1):
    - acc & ret -> ONE, main <= i_data.
    - acc & !ret -> TWO, skid <= i_data.
    - !acc & ret -> EMPTY.
    - Otherwise hold.
  - TWO (o_valid=1, o_count=2, o_ready=0):
    - ret -> ONE, main <= skid.
    - Otherwise hold.
- States when SKID=0. Single entry; state TWO is unreachable and the skid register is removed.
  - o_ready = !o_valid | i_ready (combinational, low during reset).
  - EMPTY: acc -> ONE.
  - ONE:
    - acc & ret -> ONE with the new data.
    - ret only -> EMPTY.
    - Otherwise hold.
- Data path:
  - o_data always reflects the main register; the skid register is never output directly.
  - Main register order is strictly FIFO: the skid entry is always older than any later acc.
- Latency:
  - Throughput: 1 transfer per cycle sustained.
  - EMPTY with acc at edge N: o_valid=1 and o_data=i_data in the cycle after edge N.
  - Removing downstream backpressure causes no bubble.
- Stability: while o_valid=1 & i_ready=0, o_data and o_valid hold stable (AXI-style rule), except on flush or reset.
- Masking: ZERO_INVALID=1 applies a WIDTH-wide AND of the main register with o_valid.
- Widths: o_count is 2 bits. With SKID=0 its MSB is tied to 0.

Test Plan:
1. Reset, defaults (WIDTH=32, SKID=1, RESET_VALUE=32'hDEAD_BEEF):
   - Hold reset 3 cycles with i_valid=1 -> o_valid=0, o_ready=0, o_data=DEADBEEF, o_count=0.
   - First cycle after release: o_ready=1.
2. Streaming: i_ready=1, send 1,2,3,4 back-to-back -> o_data 1,2,3,4 on consecutive cycles, each one cycle after its acc; o_count stays 1.
3. Backpressure skid:
   - i_ready=0, send A then B -> o_count=2, o_ready=0, o_data=A held; C is offered and not accepted.
   - Raise i_ready -> A, B, C delivered in order with no loss or duplicate.
4. Flush:
   - In state TWO, assert i_flush with i_valid=1 and data X -> next cycle o_valid=0, o_count=0, o_ready=1; X never appears on the output.
   - Next send Y -> Y delivered.
5. Masking and reset mid-operation:
   - ZERO_INVALID=1, after entry 32'h1234_5678 retires -> o_data=0.
   - Assert reset while in ONE -> the entry is lost and o_data=0.
6. SKID=0:
   - i_ready=0 with i_valid=1 -> o_ready=0 after the first acc; o_count never exceeds 1.
   - Toggle i_ready every cycle against a random upstream -> output sequence equals the accepted input sequence.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with optional 2-entry skid buffer; one cycle from accept to o_valid.
// SKID=1 decodes o_ready from the state register only; SKID=0 passes i_ready through combinationally.
module pipe_stage_reg #(
   parameter int               WIDTH        = 32,
   parameter bit               SKID         = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
   parameter bit               ZERO_INVALID = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [1:0]       o_count
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q;
   logic             acc, ret;

   assign o_valid = (state_q != S_EMPTY);
   assign acc     = i_valid & o_ready;
   assign ret     = o_valid & i_ready;

   generate
      if (SKID) begin : g_ready_reg
         assign o_ready = ~reset & (state_q != S_TWO);
      end else begin : g_ready_comb
         assign o_ready = ~reset & (~o_valid | i_ready);
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      if (i_flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (acc) begin
                  state_d = S_ONE;
                  main_d  = i_data;
               end
            end
            S_ONE: begin
               if (acc && ret) begin
                  main_d = i_data;
               end else if (acc && SKID) begin
                  state_d = S_TWO;
               end else if (ret) begin
                  state_d = S_EMPTY;
               end
            end
            S_TWO: begin
               // Skid entry is older than anything accepted later, so it moves up first.
               if (ret) begin
                  state_d = S_ONE;
                  main_d  = skid_q;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_EMPTY;
         main_q  <= RESET_VALUE;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
      end
   end

   generate
      if (SKID) begin : g_skid
         always_ff @(posedge clk) begin
            if (reset) begin
               skid_q <= RESET_VALUE;
            end else if (!i_flush && (state_q == S_ONE) && acc && !ret) begin
               skid_q <= i_data;
            end
         end
      end else begin : g_no_skid
         assign skid_q = RESET_VALUE;
      end
   endgenerate

   assign o_count = {(SKID && (state_q == S_TWO)), (state_q == S_ONE)};

   generate
      if (ZERO_INVALID) begin : g_mask
         assign o_data = main_q & {WIDTH{o_valid}};
      end else begin : g_nomask
         assign o_data = main_q;
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives three configurations (skid, skid+masking, single-entry) from one stimulus against a queue-style reference model.
module tb_pipe_stage_reg;

   localparam logic [31:0] RV = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst, fl, vld, rdy;
   logic [31:0] dat;

   logic        o_ready_w [3];
   logic        o_valid_w [3];
   logic [31:0] o_data_w  [3];
   logic [1:0]  o_count_w [3];

   int n_checks = 0;
   int n_fail   = 0;

   int          cnt  [3] = '{0, 0, 0};
   logic [31:0] ent  [3][2];
   logic [31:0] last [3];

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .RESET_VALUE(RV), .ZERO_INVALID(1'b0)) u0 (
      .clk(clk), .reset(rst), .i_flush(fl), .i_data(dat), .i_valid(vld), .o_ready(o_ready_w[0]),
      .o_data(o_data_w[0]), .o_valid(o_valid_w[0]), .i_ready(rdy), .o_count(o_count_w[0]));
   pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .RESET_VALUE(RV), .ZERO_INVALID(1'b1)) u1 (
      .clk(clk), .reset(rst), .i_flush(fl), .i_data(dat), .i_valid(vld), .o_ready(o_ready_w[1]),
      .o_data(o_data_w[1]), .o_valid(o_valid_w[1]), .i_ready(rdy), .o_count(o_count_w[1]));
   pipe_stage_reg #(.WIDTH(32), .SKID(1'b0), .RESET_VALUE(32'h0), .ZERO_INVALID(1'b0)) u2 (
      .clk(clk), .reset(rst), .i_flush(fl), .i_data(dat), .i_valid(vld), .o_ready(o_ready_w[2]),
      .o_data(o_data_w[2]), .o_valid(o_valid_w[2]), .i_ready(rdy), .o_count(o_count_w[2]));

   function automatic logic [31:0] rv_of(input int d);
      return (d == 2) ? 32'h0 : RV;
   endfunction

   // Model: each stage is a FIFO of capacity 2 (skid) or 1, plus the last value the output register held.
   function automatic logic m_ready(input int d);
      if (rst) return 1'b0;
      if (d != 2) return (cnt[d] < 2);
      return (cnt[d] == 0) || rdy;
   endfunction

   function automatic logic [31:0] m_data(input int d);
      if (cnt[d] > 0) return ent[d][0];
      if (d == 1) return 32'h0;
      return last[d];
   endfunction

   task automatic model_step();
      for (int d = 0; d < 3; d++) begin
         logic a, r;
         a = vld && m_ready(d);
         r = (cnt[d] > 0) && rdy;
         if (rst) begin
            cnt[d]  = 0;
            last[d] = rv_of(d);
         end else if (fl) begin
            if (cnt[d] > 0) last[d] = ent[d][0];
            cnt[d] = 0;
         end else begin
            if (r) begin
               last[d]   = ent[d][0];
               ent[d][0] = ent[d][1];
               cnt[d]    = cnt[d] - 1;
            end
            if (a) begin
               ent[d][cnt[d]] = dat;
               cnt[d]         = cnt[d] + 1;
            end
         end
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic v, input logic [31:0] x, input logic rd);
      rst = r; fl = f; vld = v; dat = x; rdy = rd;
      #1;
   endtask

   task automatic advance();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b1, 32'h55, 1'b0);
         n_checks++; if (o_ready_w[0] !== 1'b0) begin n_fail++; $display("FAIL rst_ready0 got=%0h exp=0", o_ready_w[0]); end
         n_checks++; if (o_ready_w[2] !== 1'b0) begin n_fail++; $display("FAIL rst_ready2 got=%0h exp=0", o_ready_w[2]); end
         advance();
         n_checks++; if (o_valid_w[0] !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0h exp=0", o_valid_w[0]); end
         n_checks++; if (o_data_w[0] !== RV) begin n_fail++; $display("FAIL rst_data got=%h exp=%h", o_data_w[0], RV); end
         n_checks++; if (o_count_w[0] !== 2'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", o_count_w[0]); end
         n_checks++; if (o_data_w[1] !== 32'h0) begin n_fail++; $display("FAIL rst_data_masked got=%h exp=0", o_data_w[1]); end
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      n_checks++; if (o_ready_w[0] !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got=%0h exp=1", o_ready_w[0]); end
      n_checks++; if (o_valid_w[0] !== 1'b0) begin n_fail++; $display("FAIL rst_release_valid got=%0h exp=0", o_valid_w[0]); end
   endtask

   task automatic test_streaming();
      for (int k = 1; k <= 4; k++) begin
         drive(1'b0, 1'b0, 1'b1, 32'(k), 1'b1);
         n_checks++; if (o_ready_w[0] !== 1'b1) begin n_fail++; $display("FAIL stream_ready%0d got=%0h exp=1", k, o_ready_w[0]); end
         advance();
         n_checks++; if (o_valid_w[0] !== 1'b1) begin n_fail++; $display("FAIL stream_valid%0d got=%0h exp=1", k, o_valid_w[0]); end
         n_checks++; if (o_data_w[0] !== 32'(k)) begin n_fail++; $display("FAIL stream_data%0d got=%h exp=%h", k, o_data_w[0], 32'(k)); end
         n_checks++; if (o_count_w[0] !== 2'd1) begin n_fail++; $display("FAIL stream_count%0d got=%0d exp=1", k, o_count_w[0]); end
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      advance();
      n_checks++; if (o_valid_w[0] !== 1'b0) begin n_fail++; $display("FAIL stream_drain got=%0h exp=0", o_valid_w[0]); end
      n_checks++; if (o_data_w[0] !== 32'd4) begin n_fail++; $display("FAIL stream_hold_data got=%h exp=4", o_data_w[0]); end
   endtask

   task automatic test_backpressure();
      logic [31:0] a, b, c;
      a = 32'hA0A0_0001; b = 32'hB0B0_0002; c = 32'hC0C0_0003;
      drive(1'b0, 1'b0, 1'b1, a, 1'b0); advance();
      n_checks++; if (o_count_w[0] !== 2'd1) begin n_fail++; $display("FAIL bp_count1 got=%0d exp=1", o_count_w[0]); end
      drive(1'b0, 1'b0, 1'b1, b, 1'b0); advance();
      n_checks++; if (o_count_w[0] !== 2'd2) begin n_fail++; $display("FAIL bp_count2 got=%0d exp=2", o_count_w[0]); end
      drive(1'b0, 1'b0, 1'b1, c, 1'b0);
      n_checks++; if (o_ready_w[0] !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got=%0h exp=0", o_ready_w[0]); end
      advance();
      n_checks++; if (o_count_w[0] !== 2'd2) begin n_fail++; $display("FAIL bp_hold_count got=%0d exp=2", o_count_w[0]); end
      n_checks++; if (o_data_w[0] !== a) begin n_fail++; $display("FAIL bp_hold_data got=%h exp=%h", o_data_w[0], a); end
      drive(1'b0, 1'b0, 1'b1, c, 1'b1);
      n_checks++; if (o_ready_w[0] !== 1'b0) begin n_fail++; $display("FAIL bp_drain_ready got=%0h exp=0", o_ready_w[0]); end
      n_checks++; if (o_data_w[0] !== a) begin n_fail++; $display("FAIL bp_out_a got=%h exp=%h", o_data_w[0], a); end
      advance();
      drive(1'b0, 1'b0, 1'b1, c, 1'b1);
      n_checks++; if (o_ready_w[0] !== 1'b1) begin n_fail++; $display("FAIL bp_reopen_ready got=%0h exp=1", o_ready_w[0]); end
      n_checks++; if (o_data_w[0] !== b) begin n_fail++; $display("FAIL bp_out_b got=%h exp=%h", o_data_w[0], b); end
      advance();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      n_checks++; if (o_data_w[0] !== c) begin n_fail++; $display("FAIL bp_out_c got=%h exp=%h", o_data_w[0], c); end
      n_checks++; if (o_count_w[0] !== 2'd1) begin n_fail++; $display("FAIL bp_out_c_count got=%0d exp=1", o_count_w[0]); end
      advance();
      n_checks++; if (o_valid_w[0] !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got=%0h exp=0", o_valid_w[0]); end
   endtask

   task automatic test_flush();
      logic [31:0] p, q, x, y;
      p = 32'h0000_1111; q = 32'h0000_2222; x = 32'hBAD0_BAD0; y = 32'h0000_3333;
      drive(1'b0, 1'b0, 1'b1, p, 1'b0); advance();
      drive(1'b0, 1'b0, 1'b1, q, 1'b0); advance();
      n_checks++; if (o_count_w[0] !== 2'd2) begin n_fail++; $display("FAIL fl_pre_count got=%0d exp=2", o_count_w[0]); end
      drive(1'b0, 1'b1, 1'b1, x, 1'b0); advance();
      drive(1'b0, 1'b0, 1'b1, y, 1'b1);
      n_checks++; if (o_valid_w[0] !== 1'b0) begin n_fail++; $display("FAIL fl_valid got=%0h exp=0", o_valid_w[0]); end
      n_checks++; if (o_count_w[0] !== 2'd0) begin n_fail++; $display("FAIL fl_count got=%0d exp=0", o_count_w[0]); end
      n_checks++; if (o_ready_w[0] !== 1'b1) begin n_fail++; $display("FAIL fl_ready got=%0h exp=1", o_ready_w[0]); end
      n_checks++; if (o_data_w[0] !== p) begin n_fail++; $display("FAIL fl_data_hold got=%h exp=%h", o_data_w[0], p); end
      advance();
      n_checks++; if (o_data_w[0] !== y) begin n_fail++; $display("FAIL fl_next_data got=%h exp=%h", o_data_w[0], y); end
      n_checks++; if (o_valid_w[0] !== 1'b1) begin n_fail++; $display("FAIL fl_next_valid got=%0h exp=1", o_valid_w[0]); end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); advance();
      n_checks++; if (o_count_w[0] !== 2'd0) begin n_fail++; $display("FAIL fl_drain_count got=%0d exp=0", o_count_w[0]); end
   endtask

   task automatic test_masking();
      drive(1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b1); advance();
      n_checks++; if (o_data_w[1] !== 32'h1234_5678) begin n_fail++; $display("FAIL mask_live got=%h exp=12345678", o_data_w[1]); end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); advance();
      n_checks++; if (o_data_w[1] !== 32'h0) begin n_fail++; $display("FAIL mask_retired got=%h exp=0", o_data_w[1]); end
      n_checks++; if (o_data_w[0] !== 32'h1234_5678) begin n_fail++; $display("FAIL nomask_retired got=%h exp=12345678", o_data_w[0]); end
      drive(1'b0, 1'b0, 1'b1, 32'h0000_0009, 1'b0); advance();
      n_checks++; if (o_count_w[1] !== 2'd1) begin n_fail++; $display("FAIL mask_one got=%0d exp=1", o_count_w[1]); end
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0); advance();
      n_checks++; if (o_valid_w[1] !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%0h exp=0", o_valid_w[1]); end
      n_checks++; if (o_data_w[1] !== 32'h0) begin n_fail++; $display("FAIL midrst_data got=%h exp=0", o_data_w[1]); end
      n_checks++; if (o_count_w[1] !== 2'd0) begin n_fail++; $display("FAIL midrst_count got=%0d exp=0", o_count_w[1]); end
      n_checks++; if (o_data_w[0] !== RV) begin n_fail++; $display("FAIL midrst_rv got=%h exp=%h", o_data_w[0], RV); end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_skid0();
      logic [31:0] d0;
      d0 = 32'h5A5A_0000;
      drive(1'b0, 1'b0, 1'b1, d0, 1'b0);
      n_checks++; if (o_ready_w[2] !== 1'b1) begin n_fail++; $display("FAIL s0_empty_ready got=%0h exp=1", o_ready_w[2]); end
      advance();
      for (int i = 1; i <= 4; i++) begin
         drive(1'b0, 1'b0, 1'b1, d0 + 32'(i), 1'b0);
         n_checks++; if (o_ready_w[2] !== 1'b0) begin n_fail++; $display("FAIL s0_ready%0d got=%0h exp=0", i, o_ready_w[2]); end
         n_checks++; if (o_count_w[2] !== 2'd1) begin n_fail++; $display("FAIL s0_count%0d got=%0d exp=1", i, o_count_w[2]); end
         n_checks++; if (o_data_w[2] !== d0) begin n_fail++; $display("FAIL s0_data%0d got=%h exp=%h", i, o_data_w[2], d0); end
         advance();
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); advance();
      n_checks++; if (o_valid_w[2] !== 1'b0) begin n_fail++; $display("FAIL s0_drain got=%0h exp=0", o_valid_w[2]); end
   endtask

   task automatic test_random();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0); advance();
      for (int i = 0; i < 600; i++) begin
         logic r, f;
         r = (i < 300) ? i[0] : 1'($urandom_range(0, 1));
         f = (i >= 300) && ($urandom_range(0, 15) == 0);
         drive(1'b0, f, ($urandom_range(0, 3) != 0), $urandom, r);
         for (int d = 0; d < 3; d++) begin
            logic [1:0] ec;
            ec = 2'(cnt[d]);
            n_checks++; if (o_ready_w[d] !== m_ready(d)) begin n_fail++; $display("FAIL rnd_ready dut%0d cyc%0d got=%0h exp=%0h", d, i, o_ready_w[d], m_ready(d)); end
            n_checks++; if (o_valid_w[d] !== (cnt[d] > 0)) begin n_fail++; $display("FAIL rnd_valid dut%0d cyc%0d got=%0h exp=%0h", d, i, o_valid_w[d], (cnt[d] > 0)); end
            n_checks++; if (o_data_w[d] !== m_data(d)) begin n_fail++; $display("FAIL rnd_data dut%0d cyc%0d got=%h exp=%h", d, i, o_data_w[d], m_data(d)); end
            n_checks++; if (o_count_w[d] !== ec) begin n_fail++; $display("FAIL rnd_count dut%0d cyc%0d got=%0d exp=%0d", d, i, o_count_w[d], ec); end
         end
         advance();
      end
   endtask

   initial begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_masking();
      test_skid0();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
